// File: rtl/pipe_ctrl_unit.sv
// Pipelined BatPU2 control unit: registered opcode decode, load-use stall,
// post-transfer flush, call-depth tracking and a halt/resume state machine.
module pipe_ctrl_unit #(
  parameter int OPC_W        = 4,
  parameter int REG_AW       = 4,
  parameter int CALL_DEPTH   = 16,
  parameter int FLUSH_CYCLES = 1,
  parameter int HAZARD_EN    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            inst_valid,
  output logic                            inst_ready,
  input  logic [OPC_W-1:0]                opcode,
  input  logic [REG_AW-1:0]               rd_addr,
  input  logic [REG_AW-1:0]               rs_a_addr,
  input  logic [REG_AW-1:0]               rs_b_addr,
  input  logic                            flag_in,
  input  logic                            resume,
  output logic [13:0]                     ctrl_ex,
  output logic                            ctrl_valid,
  output logic                            stall,
  output logic                            flush,
  output logic                            halted,
  output logic [$clog2(CALL_DEPTH+1)-1:0] call_depth,
  output logic [1:0]                      stack_err
);
  localparam int DW = $clog2(CALL_DEPTH+1);

  // Control words: 0 cs_en, 1 cs_sel, 2 flags_we, 3 pc_in_sel, 5 pc_jmp,
  // 9 alu_b_sel, 10-11 reg_in_sel (01 imm, 10 alu, 11 mem), 12 mem_we, 13 hlt
  localparam logic [13:0] W_HLT = 14'h2000;
  localparam logic [13:0] W_ALU = 14'h0A04;
  localparam logic [13:0] W_LDI = 14'h0400;
  localparam logic [13:0] W_ADI = 14'h0804;
  localparam logic [13:0] W_JMP = 14'h0020;
  localparam logic [13:0] W_CAL = 14'h0021;
  localparam logic [13:0] W_RET = 14'h002B;
  localparam logic [13:0] W_LOD = 14'h0C00;
  localparam logic [13:0] W_STR = 14'h1000;

  typedef enum logic [1:0] {RUN, STALL, FLUSH, HALT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        fcnt_q, fcnt_d;
  logic [13:0]       ctrl_q, ctrl_d;
  logic              vld_q, vld_d;
  logic              lod_q, lod_d;
  logic [REG_AW-1:0] lrd_q, lrd_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic [1:0]        err_q, err_d;

  logic [31:0] opx;
  logic [13:0] dec_word;
  logic        use_a, use_b, hazard, halt_pend, take, ready_c, stall_c;

  // Opcode decode and source-register usage; out-of-table opcodes are NOP
  always_comb begin
    opx      = 32'(opcode);
    dec_word = '0;
    use_a    = 1'b0;
    use_b    = 1'b0;
    case (opx)
      32'd1:  dec_word = W_HLT;
      32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7: begin
        dec_word = W_ALU;
        use_a    = 1'b1;
        use_b    = 1'b1;
      end
      32'd8:  dec_word = W_LDI;
      32'd9:  begin dec_word = W_ADI; use_a = 1'b1; end
      32'd10: dec_word = W_JMP;
      32'd11: dec_word = flag_in ? W_JMP : 14'h0000;
      32'd12: dec_word = W_CAL;
      32'd13: dec_word = W_RET;
      32'd14: begin dec_word = W_LOD; use_a = 1'b1; end
      32'd15: begin dec_word = W_STR; use_a = 1'b1; use_b = 1'b1; end
      default: ;
    endcase
  end

  // A HLT word sitting in execute blocks issue and moves the FSM to HALT next
  assign halt_pend = vld_q & ctrl_q[13];
  assign hazard    = (HAZARD_EN != 0) && inst_valid && lod_q && (lrd_q != '0) &&
                     ((use_a && (rs_a_addr == lrd_q)) || (use_b && (rs_b_addr == lrd_q)));

  // Next-state: priority is halt entry, flush, stall, then normal issue
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    ctrl_d  = '0;
    vld_d   = 1'b0;
    lod_d   = 1'b0;
    lrd_d   = '0;
    depth_d = depth_q;
    err_d   = err_q;
    ready_c = 1'b0;
    stall_c = 1'b0;
    take    = 1'b0;
    case (state_q)
      HALT: if (resume) state_d = RUN;
      FLUSH: begin
        ready_c = 1'b1;               // wrong-path slots are consumed and dropped
        if (fcnt_q == 2'd0) state_d = RUN;
        else                fcnt_d  = fcnt_q - 2'd1;
      end
      default: begin
        if (halt_pend) begin
          state_d = HALT;
        end else if (hazard) begin
          stall_c = 1'b1;
          state_d = STALL;
        end else begin
          ready_c = 1'b1;
          state_d = RUN;
          if (inst_valid) begin
            vld_d  = 1'b1;
            ctrl_d = dec_word;
            lod_d  = (opx == 32'd14);
            lrd_d  = rd_addr;
            case (opx)
              32'd10: take = 1'b1;
              32'd11: take = flag_in;
              32'd12:
                if (depth_q == DW'(CALL_DEPTH)) begin
                  err_d[0] = 1'b1;
                  ctrl_d   = W_HLT;
                end else begin
                  depth_d = depth_q + 1'b1;
                  take    = 1'b1;
                end
              32'd13:
                if (depth_q == '0) begin
                  err_d[1] = 1'b1;
                  ctrl_d   = W_HLT;
                end else begin
                  depth_d = depth_q - 1'b1;
                  take    = 1'b1;
                end
              default: ;
            endcase
            if (take) begin
              state_d = FLUSH;
              fcnt_d  = 2'(FLUSH_CYCLES - 1);
            end
          end
        end
      end
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      ctrl_q  <= '0;
      vld_q   <= 1'b0;
      lod_q   <= 1'b0;
      lrd_q   <= '0;
      depth_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      ctrl_q  <= ctrl_d;
      vld_q   <= vld_d;
      lod_q   <= lod_d;
      lrd_q   <= lrd_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  assign inst_ready = ready_c & ~rst;
  assign stall      = stall_c & ~rst;
  assign ctrl_ex    = ctrl_q;
  assign ctrl_valid = vld_q;
  assign flush      = (state_q == FLUSH);
  assign halted     = (state_q == HALT);
  assign call_depth = depth_q;
  assign stack_err  = err_q;
endmodule
